if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction and PC width in bits.
REQ-002 Parameter ADDR_SIZE, default 10, instruction-memory word-address width.
REQ-003 Parameter RESET_PC, default 0, byte address of the first fetch after reset.
REQ-004 Ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: imem_en  out  1  instruction-memory read request this cycle.
REQ-007 Ports: imem_addr  out  ADDR_SIZE  word address, equal to fetch_pc[ADDR_SIZE+1:2].
REQ-008 Ports: imem_rdata  in  WORD_SIZE  read data, valid exactly one cycle after imem_en.
REQ-009 Ports: redirect  in  1  branch/jump taken, flush and refetch.
REQ-010 Ports: redirect_pc  in  WORD_SIZE  redirect target byte address.
REQ-011 Ports: id_ready  in  1  decode stage accepts instr this cycle.
REQ-012 Ports: instr  out  WORD_SIZE  instruction presented to decode.
REQ-013 Ports: instr_pc  out  WORD_SIZE  byte PC of instr.
REQ-014 Ports: instr_valid  out  1  instr/instr_pc are valid.
REQ-015 Ports: misalign  out  1  one-cycle pulse: last redirect_pc had nonzero bits [1:0].

Function
REQ-016 Block SHALL hold fetch_pc, a 2-entry instruction buffer (instr, pc pairs), and an in-flight flag for one outstanding memory request.
REQ-017 Head buffer entry SHALL drive instr/instr_pc; instr_valid SHALL equal buffer non-empty.
REQ-018 Transfer occurs on instr_valid and id_ready in same cycle; head SHALL pop at that edge.
REQ-019 imem_en SHALL assert when (count + inflight - pop) < 2 and no redirect is pending; fetch_pc SHALL advance by 4 at each issued request.
REQ-020 Returning imem_rdata SHALL be pushed with the PC of its request, unless marked discard.
REQ-021 With id_ready held high, throughput SHALL be one instruction per cycle with no bubbles.
REQ-022 id_ready low with buffer full SHALL hold instr/instr_pc/instr_valid stable and issue no request; no instruction SHALL be lost or duplicated.
REQ-023 Redirect in cycle N SHALL: empty the buffer at edge N, mark any in-flight request discard, load fetch_pc = {redirect_pc[WORD_SIZE-1:2],2'b00}.
REQ-024 After redirect in N: instr_valid low in N+1, imem_en with target address in N+1, target instr_valid in N+2.
REQ-025 A handshake coinciding with redirect SHALL count as consumed; decode discards it.
REQ-026 Redirect in consecutive cycles: last one wins, latency measured from it.
REQ-027 misalign SHALL pulse high in N+1 for redirect in N with redirect_pc[1:0] != 0; fetch still proceeds at the aligned address.
REQ-028 fetch_pc SHALL wrap modulo 2^WORD_SIZE; imem_addr wraps modulo 2^ADDR_SIZE.

Reset
REQ-029 rst high SHALL immediately force: fetch_pc=RESET_PC, buffer empty, inflight=0, instr_valid=0, instr=32'h00000013 (NOP), instr_pc=0, imem_en=0, misalign=0.
REQ-030 First cycle after rst deassert SHALL issue imem_en at RESET_PC; first instr_valid one cycle later.
REQ-031 rst asserted mid-stream SHALL drop buffered and in-flight instructions; restart per REQ-030.

Verification
REQ-032 Reset release, id_ready=1, memory word k = k -> instr 0,1,2,3 with instr_pc 0,4,8,12 on consecutive cycles from cycle 2.
REQ-033 id_ready low 5 cycles mid-stream -> instr stable, imem_en low once buffer full, sequence resumes gap-free with no duplicate.
REQ-034 redirect=1, redirect_pc=0x40 with request in flight -> in-flight word never appears; next valid instr has instr_pc 0x40 two cycles later.
REQ-035 redirect_pc=0x42 -> misalign pulse one cycle, fetch at 0x40.
REQ-036 Redirect on two consecutive cycles (0x80 then 0x100) -> only 0x100 stream appears.
REQ-037 rst asserted while buffer full and stalled -> outputs at reset values immediately, restart at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if
//   Bundles the instruction-fetch stage's memory-request, redirect and
//   decode-handshake signals.
//   master : the fetch stage (drives imem_en/imem_addr and the decode-facing
//            instr/instr_pc/instr_valid/misalign)
//   slave  : the environment (instruction memory, branch unit, decode)
interface if_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 imem_en;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 id_ready;
  logic [WORD_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0] instr_pc;
  logic                 instr_valid;
  logic                 misalign;

  modport master (
    output imem_en, imem_addr, instr, instr_pc, instr_valid, misalign,
    input  imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr, instr_pc, instr_valid, misalign,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage with one outstanding synchronous memory read and
//   a two-entry instruction buffer in front of decode.
//   clk    : sole clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   bus_io : if_stage_if.master
//            imem_en/imem_addr out, imem_rdata in (one cycle after imem_en)
//            redirect/redirect_pc in, id_ready in
//            instr/instr_pc/instr_valid out, misalign out (one-cycle pulse)
module if_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_SIZE = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus_io
);

  localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);

  logic [WORD_SIZE-1:0] fetchPc_q, fetchPc_d;
  logic [WORD_SIZE-1:0] reqPc_q, reqPc_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           count_q, count_d;
  logic [WORD_SIZE-1:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [WORD_SIZE-1:0] instr1_q, instr1_d, pc1_q, pc1_d;
  logic                 misalign_q, misalign_d;

  logic                 headValid;
  logic [WORD_SIZE-1:0] headInstr, headPc;
  logic                 bypass, pop, push, issue;
  logic [2:0]           occupancy;

  // The returning word is presented to decode straight from the memory when
  // the buffer is empty, so a fetch shows up the cycle after its request.
  // It only enters the buffer if decode does not take it right away.
  always_comb begin
    bypass    = (count_q == 2'd0) && inflight_q;
    headValid = (count_q != 2'd0) || inflight_q;
    headInstr = bypass ? bus_io.imem_rdata : instr0_q;
    headPc    = bypass ? reqPc_q : pc0_q;
    pop       = headValid && bus_io.id_ready;
    push      = inflight_q && !(bypass && pop);
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = !rst && !bus_io.redirect && (occupancy < 3'd2);
  end

  // Next-state for PC, outstanding request and buffer. A redirect blocks the
  // request in its own cycle, so nothing is in flight afterwards and the
  // word arriving during the redirect cycle is simply never captured.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    reqPc_d    = reqPc_q;
    inflight_d = issue;
    count_d    = count_q;
    instr0_d   = instr0_q;
    pc0_d      = pc0_q;
    instr1_d   = instr1_q;
    pc1_d      = pc1_q;
    misalign_d = bus_io.redirect && (bus_io.redirect_pc[1:0] != 2'b00);

    if (bus_io.redirect) begin
      fetchPc_d = {bus_io.redirect_pc[WORD_SIZE-1:2], 2'b00};
    end else if (issue) begin
      fetchPc_d = fetchPc_q + WORD_SIZE'(4);
    end

    if (issue) begin
      reqPc_d = fetchPc_q;
    end

    if (bus_io.redirect) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            instr0_d = bus_io.imem_rdata;
            pc0_d    = reqPc_q;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            instr0_d = bus_io.imem_rdata;
            pc0_d    = reqPc_q;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (push) begin
            instr1_d = bus_io.imem_rdata;
            pc1_d    = reqPc_q;
            count_d  = 2'd2;
          end
        end
        default: begin
          // Full buffer implies nothing in flight, so only a pop can occur.
          if (pop) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            count_d  = 2'd1;
          end
        end
      endcase
    end
  end

  // State registers; reset forces the NOP/PC-0 head so outputs settle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      reqPc_q    <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      instr0_q   <= NOP;
      pc0_q      <= '0;
      instr1_q   <= NOP;
      pc1_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      reqPc_q    <= reqPc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      instr0_q   <= instr0_d;
      pc0_q      <= pc0_d;
      instr1_q   <= instr1_d;
      pc1_q      <= pc1_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus_io.imem_en     = issue;
  assign bus_io.imem_addr   = fetchPc_q[ADDR_SIZE+1:2];
  assign bus_io.instr       = headInstr;
  assign bus_io.instr_pc    = headPc;
  assign bus_io.instr_valid = headValid;
  assign bus_io.misalign    = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
//   Directed bench for if_stage. The memory model returns word k at word
//   address k one cycle after imem_en, so the instruction at byte PC p is p>>2.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) bus ();

  if_stage #(
    .WORD_SIZE(32),
    .ADDR_SIZE(10),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  // Synchronous instruction memory: data appears the cycle after the request.
  logic [31:0] memData = 32'h0;
  always @(posedge clk) begin
    if (bus.imem_en) memData <= {22'd0, bus.imem_addr};
  end
  assign bus.imem_rdata = memData;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] expPc;

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the
  // falling edge so outputs can be sampled away from the active edge.
  task automatic applyStimulus(input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.id_ready    = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(negedge clk);
  endtask

  // The head must be the next expected instruction; advance on handshake.
  task automatic checkStream(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    checkOutput({tag, "_pc"}, bus.instr_pc, expPc);
    checkOutput({tag, "_instr"}, bus.instr, expPc >> 2);
    if (bus.id_ready) expPc = expPc + 32'd4;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    checkOutput({tag, "_instr"}, bus.instr, 32'h0000_0013);
    checkOutput({tag, "_pc"}, bus.instr_pc, 32'd0);
    checkOutput({tag, "_en"}, {31'd0, bus.imem_en}, 32'd0);
    checkOutput({tag, "_misalign"}, {31'd0, bus.misalign}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    expPc           = 32'h0;
    #2;
    checkReset("rst0");

    // Reset release: request at RESET_PC in the first cycle.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checkOutput("first_en", {31'd0, bus.imem_en}, 32'd1);
    checkOutput("first_addr", {22'd0, bus.imem_addr}, 32'd0);
    checkOutput("first_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Back-to-back stream 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkStream("seq");
    end

    // Stall five cycles: head held, requests stop once the buffer is full.
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkStream("stall0");
    checkOutput("stall0_en", {31'd0, bus.imem_en}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkStream("stall");
      checkOutput("stall_en", {31'd0, bus.imem_en}, 32'd0);
    end

    // Resume gap-free, no duplicate.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkStream("resume");
    end

    // Redirect to 0x40 while a request is outstanding.
    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("redir_en", {31'd0, bus.imem_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_n1_valid", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("redir_n1_en", {31'd0, bus.imem_en}, 32'd1);
    checkOutput("redir_n1_addr", {22'd0, bus.imem_addr}, 32'h10);
    checkOutput("redir_n1_misalign", {31'd0, bus.misalign}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    expPc = 32'h40;
    checkStream("redir_n2");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkStream("redir_run");
    end

    // Misaligned redirect target.
    applyStimulus(1'b1, 1'b1, 32'h42);
    checkOutput("mis_n0", {31'd0, bus.misalign}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mis_n1", {31'd0, bus.misalign}, 32'd1);
    checkOutput("mis_n1_addr", {22'd0, bus.imem_addr}, 32'h10);
    checkOutput("mis_n1_valid", {31'd0, bus.instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mis_n2", {31'd0, bus.misalign}, 32'd0);
    expPc = 32'h40;
    checkStream("mis_n2");

    // Two consecutive redirects: only the second target is fetched.
    applyStimulus(1'b1, 1'b1, 32'h80);
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("dbl_e1_en", {31'd0, bus.imem_en}, 32'd0);
    checkOutput("dbl_e1_valid", {31'd0, bus.instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("dbl_e2_valid", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("dbl_e2_en", {31'd0, bus.imem_en}, 32'd1);
    checkOutput("dbl_e2_addr", {22'd0, bus.imem_addr}, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    expPc = 32'h100;
    checkStream("dbl_e3");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkStream("dbl_run");
    end

    // Fill the buffer while stalled, then reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkStream("full");
    end
    checkOutput("full_en", {31'd0, bus.imem_en}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    checkReset("rst_mid");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checkOutput("restart_en", {31'd0, bus.imem_en}, 32'd1);
    checkOutput("restart_addr", {22'd0, bus.imem_addr}, 32'd0);
    checkOutput("restart_valid", {31'd0, bus.instr_valid}, 32'd0);
    expPc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkStream("restart");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
